// File: rtl/bus_ctrl_pkg.sv
// Shared definitions for the bus transfer sequencer slice: FSM state type
// and the default immediate data-path width.
package bus_ctrl_pkg;

  localparam int unsigned DEFAULT_BUS_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_LATCH = 3'd2,
    ST_HOLD  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/onehot_decode.sv
// Index-to-one-hot decoder with enable; indices >= N decode to all zeros.
module onehot_decode #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic [W-1:0] idx,
  input  logic         en,
  output logic [N-1:0] oh
);

  always_comb begin
    oh = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (en && (idx == W'(i))) oh[i] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Sequences one register/immediate bus transfer at a time through
// drive, latch and hold phases with registered one-hot strobes.
module bus_transfer_sequencer
  import bus_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned BUS_W    = DEFAULT_BUS_W,
  parameter int unsigned SETTLE   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [IDX_W-1:0]    req_src,
  input  logic [IDX_W-1:0]    req_dst,
  input  logic                req_imm_en,
  input  logic [BUS_W-1:0]    req_imm,
  output logic [NUM_REGS-1:0] enable_oh,
  output logic [NUM_REGS-1:0] latch_oh,
  output logic                imm_drive_en,
  output logic [BUS_W-1:0]    imm_data,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [IDX_W:0] REG_LIM  = (IDX_W + 1)'(NUM_REGS);
  localparam logic [3:0]     CNT_LOAD = 4'(SETTLE - 1);

  state_t              state, state_n;
  logic [3:0]          cnt, cnt_n;
  logic [IDX_W-1:0]    src_q, dst_q, src_sel, dst_sel;
  logic                imm_en_q, imm_sel;
  logic                accept, req_ok, driving_n;
  logic [NUM_REGS-1:0] src_oh, dst_oh;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    req_ok = ({1'b0, req_dst} < REG_LIM);
    if (!req_imm_en)
      req_ok = req_ok && ({1'b0, req_src} < REG_LIM) && (req_src != req_dst);
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_n = req_ok ? ST_DRIVE : ST_ERR;
          cnt_n   = CNT_LOAD;
        end
      end
      ST_DRIVE: begin
        if (cnt == 4'd0) state_n = ST_LATCH;
        else             cnt_n   = cnt - 4'd1;
      end
      ST_LATCH: state_n = ST_HOLD;
      ST_HOLD:  state_n = ST_IDLE;
      ST_ERR:   state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state, so on the accepting edge the
  // incoming request fields are used instead of the not-yet-captured copies.
  assign src_sel   = accept ? req_src    : src_q;
  assign dst_sel   = accept ? req_dst    : dst_q;
  assign imm_sel   = accept ? req_imm_en : imm_en_q;
  assign driving_n = state_n inside {ST_DRIVE, ST_LATCH, ST_HOLD};

  onehot_decode #(.N(NUM_REGS), .W(IDX_W)) u_src_dec (
    .idx (src_sel),
    .en  (driving_n && !imm_sel),
    .oh  (src_oh)
  );

  onehot_decode #(.N(NUM_REGS), .W(IDX_W)) u_dst_dec (
    .idx (dst_sel),
    .en  (state_n == ST_LATCH),
    .oh  (dst_oh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      imm_en_q     <= 1'b0;
      enable_oh    <= '0;
      latch_oh     <= '0;
      imm_drive_en <= 1'b0;
      imm_data     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      enable_oh    <= src_oh;
      latch_oh     <= dst_oh;
      imm_drive_en <= driving_n && imm_sel;
      busy         <= driving_n;
      done         <= (state_n == ST_HOLD);
      err          <= (state_n == ST_ERR);
      if (accept) begin
        src_q    <= req_src;
        dst_q    <= req_dst;
        imm_en_q <= req_imm_en;
        if (req_ok && req_imm_en) imm_data <= req_imm;
      end
    end
  end

endmodule
